// File: rtl/event_unit_pkg.sv
// Shared definitions for the APB priority service unit: register offsets,
// FSM state encoding and ACK word layout.
package event_unit_pkg;

  localparam logic [4:0] OFS_ENABLE  = 5'h00;
  localparam logic [4:0] OFS_PENDING = 5'h04;
  localparam logic [4:0] OFS_SET     = 5'h08;
  localparam logic [4:0] OFS_CLEAR   = 5'h0C;
  localparam logic [4:0] OFS_ACK     = 5'h10;
  localparam logic [4:0] OFS_STATUS  = 5'h14;
  localparam logic [4:0] OFS_TYPE    = 5'h18;

  localparam int ACK_VLD_BIT = 31;

  typedef enum logic {
    ST_IDLE,
    ST_SERVING
  } state_e;

endpackage

// File: rtl/event_prio_enc.sv
// Highest-index-wins priority encoder over the pending lines; purely combinational.
module event_prio_enc #(
  parameter int NUM_LINES = 32,
  localparam int ID_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic [NUM_LINES-1:0] req_i,
  output logic [ID_W-1:0]      idx_o,
  output logic                 any_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (req_i[i]) idx_o = ID_W'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/apb_priority_service_unit.sv
// APB event/interrupt unit: latches enabled lines into PENDING and claims the highest one into ACK.
// Optional TYPE register and edge detection are built only with EVENT_UNIT_EDGE_DETECT_EN.
module apb_priority_service_unit
  import event_unit_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_LINES      = 32,
  localparam int ID_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_LINES-1:0]      signal_i,
  input  logic                      core_sleeping_i,
  output logic                      irq_o,
  output logic [ID_W-1:0]           irq_id_o
);

  logic [NUM_LINES-1:0] en_q, en_d, pend_q, pend_d, cond, wdat;
  logic [ID_W-1:0]      ack_id_q, ack_id_d, top_id;
  logic                 ack_vld_q, ack_vld_d, top_any;
  state_e               state_q, state_d;
  logic                 access, mapped, err, wr, rd;
  logic [4:0]           ofs;
  logic [31:0]          ack_word;
  logic                 unused_bits;

  assign access      = PSEL && PENABLE;
  assign ofs         = {PADDR[4:2], 2'b00};
  assign wdat        = PWDATA[NUM_LINES-1:0];
  assign unused_bits = ^{PADDR[1:0], PWDATA};

`ifdef EVENT_UNIT_EDGE_DETECT_EN
  logic [NUM_LINES-1:0] type_q, type_d, hist_q;

  // TYPE=1 lines fire only on a rising transition against last cycle's sample
  assign cond = (type_q & signal_i & ~hist_q) | (~type_q & signal_i);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      type_q <= '0;
      hist_q <= '0;
    end else begin
      type_q <= type_d;
      hist_q <= signal_i;
    end
  end

  always_comb begin
    type_d = type_q;
    if (wr && ofs == OFS_TYPE) type_d = wdat;
  end
`else
  assign cond = signal_i;
`endif

  always_comb begin
    case (ofs)
      OFS_ENABLE, OFS_PENDING, OFS_SET, OFS_CLEAR, OFS_ACK, OFS_STATUS: mapped = 1'b1;
`ifdef EVENT_UNIT_EDGE_DETECT_EN
      OFS_TYPE: mapped = 1'b1;
`endif
      default: mapped = 1'b0;
    endcase
  end

  assign err = access && (!mapped || (|PADDR[APB_ADDR_WIDTH-1:5]));
  assign wr  = access && PWRITE && !err;
  assign rd  = access && !PWRITE && !err;

  event_prio_enc #(.NUM_LINES(NUM_LINES)) u_prio (
    .req_i (pend_q),
    .idx_o (top_id),
    .any_o (top_any)
  );

  // Update order matters: write, CLEAR, SET, claim, then capture has the last word
  always_comb begin
    en_d      = en_q;
    pend_d    = pend_q;
    state_d   = state_q;
    ack_vld_d = ack_vld_q;
    ack_id_d  = ack_id_q;
    if (wr && ofs == OFS_ENABLE)  en_d   = wdat;
    if (wr && ofs == OFS_PENDING) pend_d = wdat;
    if (wr && ofs == OFS_CLEAR)   pend_d = pend_d & ~wdat;
    if (wr && ofs == OFS_SET)     pend_d = pend_d | wdat;
    case (state_q)
      ST_IDLE: begin
        if (top_any) begin
          state_d   = ST_SERVING;
          ack_vld_d = 1'b1;
          ack_id_d  = top_id;
          pend_d    = pend_d & ~(NUM_LINES'(1) << top_id);
        end
      end
      ST_SERVING: begin
        if (rd && ofs == OFS_ACK) begin
          state_d   = ST_IDLE;
          ack_vld_d = 1'b0;
          ack_id_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pend_d = pend_d | (en_q & cond);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q      <= '0;
      pend_q    <= '0;
      state_q   <= ST_IDLE;
      ack_vld_q <= 1'b0;
      ack_id_q  <= '0;
    end else begin
      en_q      <= en_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      ack_vld_q <= ack_vld_d;
      ack_id_q  <= ack_id_d;
    end
  end

  always_comb begin
    ack_word              = 32'(ack_id_q);
    ack_word[ACK_VLD_BIT] = ack_vld_q;
  end

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      case (ofs)
        OFS_ENABLE:  PRDATA = 32'(en_q);
        OFS_PENDING: PRDATA = 32'(pend_q);
        OFS_ACK:     PRDATA = ack_word;
        OFS_STATUS:  PRDATA = {state_q == ST_SERVING, |pend_q, 30'b0};
`ifdef EVENT_UNIT_EDGE_DETECT_EN
        OFS_TYPE:    PRDATA = 32'(type_q);
`endif
        default:     PRDATA = '0;
      endcase
    end
  end

  assign PREADY   = 1'b1;
  assign PSLVERR  = err;
  assign irq_o    = (|pend_q) | ((state_q == ST_SERVING) & core_sleeping_i);
  assign irq_id_o = ack_id_q;

endmodule

// File: tb/tb_apb_priority_service_unit.sv
// Directed bench: a register-access vector table followed by hand-written
// multi-cycle sequences for priority, SET/CLEAR, collision, sleep and reset.
module tb_apb_priority_service_unit;

  logic        HCLK, HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic [31:0] signal_i;
  logic        core_sleeping_i, irq_o;
  logic [4:0]  irq_id_o;

  int total = 0;
  int bad   = 0;

  apb_priority_service_unit #(.APB_ADDR_WIDTH(12), .NUM_LINES(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .signal_i(signal_i),
    .core_sleeping_i(core_sleeping_i), .irq_o(irq_o), .irq_id_o(irq_id_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] rdat, output logic er);
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1;
    rdat = PRDATA;
    er   = PSLVERR;
    @(posedge HCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    apb(1'b0, a, 32'h0, r, e);
    chk(nm, r, exp);
  endtask

  task automatic wr_do(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        e;
    apb(1'b1, a, d, r, e);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0;
    PENABLE = 1'b0; signal_i = '0; core_sleeping_i = 1'b0;

    // register-level vectors: claims between accesses are accounted for in the expectations
    vecs[0]  = '{1'b0, 12'h000, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b1, 12'h000, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 12'h000, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{1'b1, 12'h000, 32'h0,         32'h0,         1'b0};
    vecs[4]  = '{1'b0, 12'h008, 32'h0,         32'h0,         1'b0};
    vecs[5]  = '{1'b0, 12'h01C, 32'h0,         32'h0,         1'b1};
`ifdef EVENT_UNIT_EDGE_DETECT_EN
    vecs[6]  = '{1'b0, 12'h018, 32'h0,         32'h0,         1'b0};
`else
    vecs[6]  = '{1'b0, 12'h018, 32'h0,         32'h0,         1'b1};
`endif
    vecs[7]  = '{1'b0, 12'h020, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b1, 12'h040, 32'h0000_00FF, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 12'h000, 32'h0,         32'h0,         1'b0};
    vecs[10] = '{1'b0, 12'h014, 32'h0,         32'h0,         1'b0};
    vecs[11] = '{1'b0, 12'h010, 32'h0,         32'h0,         1'b0};
    vecs[12] = '{1'b1, 12'h004, 32'h0000_0010, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 12'h010, 32'h0,         32'h8000_0004, 1'b0};
    vecs[14] = '{1'b0, 12'h010, 32'h0,         32'h0,         1'b0};
    vecs[15] = '{1'b1, 12'h004, 32'h0000_0003, 32'h0,         1'b0};
    vecs[16] = '{1'b0, 12'h014, 32'h0,         32'hC000_0000, 1'b0};
    vecs[17] = '{1'b0, 12'h004, 32'h0,         32'h0000_0001, 1'b0};
    vecs[18] = '{1'b0, 12'h010, 32'h0,         32'h8000_0001, 1'b0};
    vecs[19] = '{1'b0, 12'h010, 32'h0,         32'h8000_0000, 1'b0};
    vecs[20] = '{1'b0, 12'h014, 32'h0,         32'h0,         1'b0};

    repeat (2) @(negedge HCLK);
    #1;
    chk("rst_prdata",  PRDATA,   32'h0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    chk("rst_pready",  {31'b0, PREADY},  32'h1);
    chk("rst_irq",     {31'b0, irq_o},   32'h0);
    chk("rst_irq_id",  {27'b0, irq_id_o}, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, r, e);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
    end

    // priority: 0xA0 pulse claims 7 first, then 5
    wr_do(12'h000, 32'h0000_00A0);
    @(negedge HCLK); signal_i = 32'h0000_00A0;
    @(negedge HCLK); signal_i = 32'h0;
    @(negedge HCLK); #1;
    chk("prio_irq",    {31'b0, irq_o},    32'h1);
    chk("prio_irq_id", {27'b0, irq_id_o}, 32'd7);
    rd_chk("prio_pending", 12'h004, 32'h0000_0020);
    rd_chk("prio_ack7",    12'h010, 32'h8000_0007);
    rd_chk("prio_ack5",    12'h010, 32'h8000_0005);
    wr_do(12'h000, 32'h0);

    // SET then CLEAR with ENABLE=0; then sleep gating of irq_o
    wr_do(12'h008, 32'h0000_0003);
    wr_do(12'h00C, 32'h0000_0001);
    @(negedge HCLK); #1;
    chk("sc_irq",    {31'b0, irq_o},    32'h0);
    chk("sc_irq_id", {27'b0, irq_id_o}, 32'd1);
    rd_chk("sc_pending", 12'h004, 32'h0);
    rd_chk("sc_status",  12'h014, 32'h8000_0000);
    core_sleeping_i = 1'b1; #1;
    chk("sleep_irq_hi", {31'b0, irq_o}, 32'h1);
    core_sleeping_i = 1'b0; #1;
    chk("sleep_irq_lo", {31'b0, irq_o}, 32'h0);
    rd_chk("sc_ack", 12'h010, 32'h8000_0001);

    // capture beats CLEAR on the same line
    wr_do(12'h000, 32'h0000_0004);
    @(negedge HCLK); signal_i = 32'h0000_0004;
    repeat (3) @(negedge HCLK);
    wr_do(12'h00C, 32'h0000_0004);
    rd_chk("coll_pending", 12'h004, 32'h0000_0004);
    signal_i = 32'h0;
    wr_do(12'h000, 32'h0);
    wr_do(12'h00C, 32'h0000_0004);
    rd_chk("coll_ack", 12'h010, 32'h8000_0002);
    @(negedge HCLK); #1;
    chk("coll_irq", {31'b0, irq_o}, 32'h0);

    // reset during SERVING drops the claim without re-pending
    wr_do(12'h008, 32'h0000_0100);
    repeat (2) @(negedge HCLK);
    core_sleeping_i = 1'b1; #1;
    chk("rstsv_irq_id", {27'b0, irq_id_o}, 32'd8);
    chk("rstsv_irq",    {31'b0, irq_o},    32'h1);
    HRESETn = 1'b0; #1;
    chk("rstsv_irq_after",    {31'b0, irq_o},    32'h0);
    chk("rstsv_irq_id_after", {27'b0, irq_id_o}, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1; core_sleeping_i = 1'b0;
    rd_chk("rstsv_ack",     12'h010, 32'h0);
    rd_chk("rstsv_status",  12'h014, 32'h0);
    rd_chk("rstsv_pending", 12'h004, 32'h0);

`ifdef EVENT_UNIT_EDGE_DETECT_EN
    wr_do(12'h018, 32'h0000_0001);
    wr_do(12'h000, 32'h0000_0001);
    @(negedge HCLK); signal_i = 32'h0000_0001;
    repeat (10) @(negedge HCLK);
    rd_chk("edge_ack",     12'h010, 32'h8000_0000);
    rd_chk("edge_pending", 12'h004, 32'h0);
    rd_chk("edge_ack2",    12'h010, 32'h0);
    signal_i = 32'h0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
